cache_refill_buffer: RTL and testbench
======================================

# cache_refill_buffer

Line-fill stage directly upstream of `data_array` in the unified cache. It accepts a refill request carrying a target set and way, then collects the cache block from the memory side as a sequence of narrow beats. It issues one full-block write into `data_array` once granted the array port, and signals completion with a one-cycle pulse.

## Interface
Parameters:
- `CACHE_BLOCK_SIZE_IN_BITS`, 64, block width; equals `data_array` block width.
- `BEAT_WIDTH_IN_BITS`, 16, memory beat width; must divide `CACHE_BLOCK_SIZE_IN_BITS`; ratio `BEATS` ≥ 2.
- `NUMBER_SETS`, 64, sets in `data_array`.
- `NUMBER_WAYS`, 16, ways in `data_array`.
- `SET_PTR_WIDTH_IN_BITS`, `$clog2(NUMBER_SETS)`, set index width.

Ports:
- `clk_in` in 1: single clock.
- `reset_in` in 1: synchronous, active-high reset.
- `refill_req_valid_in` in 1: refill request valid.
- `refill_req_ready_out` out 1: request accepted when valid&ready.
- `refill_set_addr_in` in `SET_PTR_WIDTH_IN_BITS`: target set.
- `refill_way_select_in` in `NUMBER_WAYS`: target way mask (one-hot expected; passed through unmodified).
- `mem_beat_valid_in` in 1: memory beat valid.
- `mem_beat_ready_out` out 1: beat consumed when valid&ready.
- `mem_beat_data_in` in `BEAT_WIDTH_IN_BITS`: beat payload.
- `mem_beat_last_in` in 1: memory marks final beat; used only for checking.
- `array_grant_in` in 1: `data_array` port granted to this block this cycle.
- `access_en_out` out 1: to `data_array.access_en_in`.
- `write_en_out` out 1: to `data_array.write_en_in`.
- `access_set_addr_out` out `SET_PTR_WIDTH_IN_BITS`: to `data_array.access_set_addr_in`.
- `way_select_out` out `NUMBER_WAYS`: to `data_array.way_select_in`.
- `write_data_out` out `CACHE_BLOCK_SIZE_IN_BITS`: to `data_array.write_data_in`.
- `refill_done_out` out 1: one-cycle completion pulse.
- `refill_error_out` out 1: sticky beat-framing error.

## Operation
- FSM states: IDLE, FILL, WRITE. Beat counter width is `$clog2(BEATS)`.
- IDLE:
  - `refill_req_ready_out`=1.
  - On valid&ready: capture set and way, clear the counter and block buffer, go to FILL.
- FILL:
  - `mem_beat_ready_out`=1.
  - Each accepted beat is written into buffer slice `[cnt*BEAT_WIDTH +: BEAT_WIDTH]`, so beat 0 lands in the LSBs. The counter then increments.
  - The accepted beat with cnt==`BEATS-1` moves the FSM to WRITE.
  - Cycles without `mem_beat_valid_in` stall the FSM with no change.
- WRITE:
  - `access_en_out`=`write_en_out`=1.
  - `access_set_addr_out`, `way_select_out` and `write_data_out` hold the captured values, stable until granted.
  - When `array_grant_in`=1, the write lands that cycle; next cycle the FSM is IDLE and `refill_done_out`=1 for one cycle.
  - While `array_grant_in`=0, the FSM holds in WRITE indefinitely.
- Output decode:
  - All handshake and array-control outputs decode from the state register only; there is no combinational input-to-output path.
  - Outside WRITE, `access_en_out`, `write_en_out` and `way_select_out` are 0. `write_data_out` and `access_set_addr_out` show the buffer and captured set.
- Framing check:
  - `mem_beat_last_in`=1 on a non-final beat, or 0 on the final beat, sets `refill_error_out`, which stays set until reset.
  - Control ignores `mem_beat_last_in`; the line is always written after exactly `BEATS` beats.
- Requests arriving in FILL or WRITE are not accepted (ready=0) and must be held by the requester.

## Timing
- Reset state, from the cycle after `reset_in` is sampled high:
  - State IDLE, counter 0, buffer 0, captured set/way 0.
  - `refill_req_ready_out`=1.
  - `mem_beat_ready_out`, `access_en_out`, `write_en_out`, `refill_done_out` and `refill_error_out` are 0.
  - `way_select_out`=0, `write_data_out`=0, `access_set_addr_out`=0.
- Minimum latency, with the request accepted in cycle 0:
  - Beats accepted in cycles 1..`BEATS`.
  - WRITE in cycle `BEATS`+1; with grant there, done in cycle `BEATS`+2.
  - With defaults: done in cycle 6.
- Back-to-back: a new request can be accepted in the same cycle `refill_done_out` pulses.
- Reset mid-FILL or mid-WRITE: the refill is abandoned. No write is issued, no done pulse occurs, and partial data is cleared.
- A beat presented while not in FILL is not consumed.

## Test plan
- Basic fill:
  - Stimulus: set=63, way=16'h8000, beats 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF (last on the 4th), grant tied 1, request in cycle 0.
  - Response: cycle 5 shows access_en=write_en=1, write_data_out=64'hFFFFFFFF00000000, set=63. Cycle 6 shows done=1 and error=0. A `data_array` readback equals the written block.
- Grant backpressure:
  - Stimulus: as in basic fill, with grant held 0 for 3 cycles in WRITE.
  - Response: outputs are stable all 4 cycles, exactly one write, and done fires the cycle after grant.
- Beat gaps:
  - Stimulus: `mem_beat_valid_in` toggling 1,0,0,1,0,1,1.
  - Response: exactly 4 beats are captured in order, data is correct, and WRITE is entered after the 4th accepted beat.
- Framing error:
  - Stimulus: last asserted on beat 1.
  - Response: `refill_error_out`=1 from the next cycle and held. The line is still written after 4 beats and done still pulses.
- Reset mid-fill:
  - Stimulus: `reset_in` pulsed after beat 2.
  - Response: no write enable at any time and no done pulse. The next request is accepted the cycle after reset and completes normally.
- Back-to-back requests:
  - Stimulus: second request held valid from cycle 1.
  - Response: ready=0 until the done cycle; the second request is accepted in that cycle and its data does not mix with the first block.

Source files
------------

// File: rtl/cache_refill_buffer.sv
// Line-fill stage in front of data_array. Accepts a refill request (set + way),
// gathers BEATS narrow memory beats into a block buffer with beat 0 in the LSBs,
// then holds a single full-block write towards data_array until the array port
// is granted. A one-cycle done pulse follows the granted write.
//
// Handshake semantics (both request and beat channels): a transfer happens on a
// rising clk_in edge where valid and ready are both 1. Ready depends only on the
// state register, so it never combinationally follows valid. A requester must
// hold valid and payload stable until the transfer happens.
module cache_refill_buffer #(
    parameter int CACHE_BLOCK_SIZE_IN_BITS = 64,
    parameter int BEAT_WIDTH_IN_BITS       = 16,
    parameter int NUMBER_SETS              = 64,
    parameter int NUMBER_WAYS              = 16,
    parameter int SET_PTR_WIDTH_IN_BITS    = $clog2(NUMBER_SETS)
) (
    input  logic                                clk_in,
    input  logic                                reset_in,
    input  logic                                refill_req_valid_in,
    output logic                                refill_req_ready_out,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]    refill_set_addr_in,
    input  logic [NUMBER_WAYS-1:0]              refill_way_select_in,
    input  logic                                mem_beat_valid_in,
    output logic                                mem_beat_ready_out,
    input  logic [BEAT_WIDTH_IN_BITS-1:0]       mem_beat_data_in,
    input  logic                                mem_beat_last_in,
    input  logic                                array_grant_in,
    output logic                                access_en_out,
    output logic                                write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]    access_set_addr_out,
    output logic [NUMBER_WAYS-1:0]              way_select_out,
    output logic [CACHE_BLOCK_SIZE_IN_BITS-1:0] write_data_out,
    output logic                                refill_done_out,
    output logic                                refill_error_out
);

    localparam int BEATS = CACHE_BLOCK_SIZE_IN_BITS / BEAT_WIDTH_IN_BITS;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    // Encoding is visible hierarchically as "state" for checkers and waveforms.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                               state;
    state_t                               state_next;
    logic [CNT_W-1:0]                     cnt;
    logic [CACHE_BLOCK_SIZE_IN_BITS-1:0]  buffer;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     set_q;
    logic [NUMBER_WAYS-1:0]               way_q;
    logic                                 done_q;
    logic                                 error_q;

    logic req_fire;
    logic beat_fire;
    logic write_fire;
    logic last_slot;

    assign req_fire   = (state == IDLE)  && refill_req_valid_in;
    assign beat_fire  = (state == FILL)  && mem_beat_valid_in;
    assign write_fire = (state == WRITE) && array_grant_in;
    assign last_slot  = (cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the line is always written after exactly BEATS beats,
    // regardless of what the memory side signals on mem_beat_last_in.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (refill_req_valid_in) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (mem_beat_valid_in && last_slot) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (array_grant_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Beat counter: cleared on a new request, advanced per accepted beat.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cnt <= '0;
        end else if (req_fire) begin
            cnt <= '0;
        end else if (beat_fire) begin
            if (last_slot) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Block buffer: beat cnt lands in slice cnt, beat 0 in the LSBs.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            buffer <= '0;
        end else if (req_fire) begin
            buffer <= '0;
        end else if (beat_fire) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt == CNT_W'(i)) begin
                    buffer[i*BEAT_WIDTH_IN_BITS +: BEAT_WIDTH_IN_BITS] <= mem_beat_data_in;
                end
            end
        end
    end

    // Target set and way captured at request acceptance, held until the next one.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            set_q <= '0;
            way_q <= '0;
        end else if (req_fire) begin
            set_q <= refill_set_addr_in;
            way_q <= refill_way_select_in;
        end
    end

    // Done pulse appears the cycle after the granted write.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            done_q <= 1'b0;
        end else begin
            done_q <= write_fire;
        end
    end

    // Sticky framing error: last flag must be set on exactly the final beat.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            error_q <= 1'b0;
        end else if (beat_fire && (mem_beat_last_in != last_slot)) begin
            error_q <= 1'b1;
        end
    end

    // Output decode from registers only; no input reaches an output combinationally.
    always_comb begin
        refill_req_ready_out = 1'b0;
        mem_beat_ready_out   = 1'b0;
        access_en_out        = 1'b0;
        write_en_out         = 1'b0;
        way_select_out       = '0;
        case (state)
            IDLE: begin
                refill_req_ready_out = 1'b1;
            end
            FILL: begin
                mem_beat_ready_out = 1'b1;
            end
            WRITE: begin
                access_en_out  = 1'b1;
                write_en_out   = 1'b1;
                way_select_out = way_q;
            end
            default: begin
                refill_req_ready_out = 1'b0;
            end
        endcase
        access_set_addr_out = set_q;
        write_data_out      = buffer;
        refill_done_out     = done_q;
        refill_error_out    = error_q;
    end

endmodule

// File: tb/tb_cache_refill_buffer.sv
// Bench for cache_refill_buffer: directed scenarios plus randomized refills.
// A transaction-level model tracks what the block must be doing and what it
// must present each cycle; a write scoreboard holds the blocks the stimulus
// intends to land in data_array.
module tb_cache_refill_buffer;

    localparam int BW    = 16;
    localparam int CW    = 64;
    localparam int SW    = 6;
    localparam int NW    = 16;
    localparam int BEATS = CW / BW;
    localparam int TMO   = 200;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          refill_req_valid_in;
    logic          refill_req_ready_out;
    logic [SW-1:0] refill_set_addr_in;
    logic [NW-1:0] refill_way_select_in;
    logic          mem_beat_valid_in;
    logic          mem_beat_ready_out;
    logic [BW-1:0] mem_beat_data_in;
    logic          mem_beat_last_in;
    logic          array_grant_in;
    logic          access_en_out;
    logic          write_en_out;
    logic [SW-1:0] access_set_addr_out;
    logic [NW-1:0] way_select_out;
    logic [CW-1:0] write_data_out;
    logic          refill_done_out;
    logic          refill_error_out;

    cache_refill_buffer #(
        .CACHE_BLOCK_SIZE_IN_BITS(CW),
        .BEAT_WIDTH_IN_BITS(BW),
        .NUMBER_SETS(64),
        .NUMBER_WAYS(NW)
    ) dut (
        .clk_in(clk),
        .reset_in(reset_in),
        .refill_req_valid_in(refill_req_valid_in),
        .refill_req_ready_out(refill_req_ready_out),
        .refill_set_addr_in(refill_set_addr_in),
        .refill_way_select_in(refill_way_select_in),
        .mem_beat_valid_in(mem_beat_valid_in),
        .mem_beat_ready_out(mem_beat_ready_out),
        .mem_beat_data_in(mem_beat_data_in),
        .mem_beat_last_in(mem_beat_last_in),
        .array_grant_in(array_grant_in),
        .access_en_out(access_en_out),
        .write_en_out(write_en_out),
        .access_set_addr_out(access_set_addr_out),
        .way_select_out(way_select_out),
        .write_data_out(write_data_out),
        .refill_done_out(refill_done_out),
        .refill_error_out(refill_error_out)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [SW+NW+CW-1:0] exp_q[$];
    int acc_log[$];
    int n_writes = 0;
    int n_done   = 0;
    int wr_cyc   = 0;
    int done_cyc = 0;
    logic [CW-1:0] last_wr_data;
    logic [SW-1:0] last_wr_set;
    logic [CW-1:0] arr [64][16];

    int grant_pct  = 100;
    int grant_hold = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    // ---------------- behavioural model ----------------
    // What the block is doing: collecting beats, waiting for the array port,
    // or free. Outputs follow from that plus the data it has gathered.
    bit            m_valid = 0;
    bit            m_fill;
    bit            m_write;
    int            m_beats;
    logic [CW-1:0] m_block;
    logic [SW-1:0] m_set;
    logic [NW-1:0] m_way;
    bit            m_done;
    bit            m_err;

    // Compare on the falling edge, then advance the model with the inputs the
    // next rising edge will sample.
    always @(negedge clk) begin : cmp_proc
        logic [SW+NW+CW-1:0] e;
        int wi;
        bit nd;
        if (m_valid) begin
            check("req_ready", 64'(refill_req_ready_out), 64'(!(m_fill || m_write)));
            check("beat_ready", 64'(mem_beat_ready_out), 64'(m_fill));
            check("access_en", 64'(access_en_out), 64'(m_write));
            check("write_en", 64'(write_en_out), 64'(m_write));
            check("way_sel", 64'(way_select_out), 64'(m_write ? m_way : 16'd0));
            check("set_addr", 64'(access_set_addr_out), 64'(m_set));
            check("wdata", write_data_out, m_block);
            check("done", 64'(refill_done_out), 64'(m_done));
            check("error", 64'(refill_error_out), 64'(m_err));

            if (refill_req_valid_in && refill_req_ready_out && !reset_in)
                acc_log.push_back(cyc);
            if (refill_done_out) begin
                done_cyc = cyc;
                n_done++;
            end
            if (access_en_out && write_en_out && array_grant_in && !reset_in) begin
                n_writes++;
                wr_cyc = cyc;
                last_wr_data = write_data_out;
                last_wr_set  = access_set_addr_out;
                wi = 0;
                for (int k = 0; k < NW; k++) if (way_select_out[k]) wi = k;
                arr[access_set_addr_out][wi] = write_data_out;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_write @cyc %0d: got set %0d data %h, required no write",
                             cyc, access_set_addr_out, write_data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_set", 64'(access_set_addr_out), 64'(e[SW+NW+CW-1 -: SW]));
                    check("sb_way", 64'(way_select_out), 64'(e[NW+CW-1 -: NW]));
                    check("sb_data", write_data_out, e[CW-1:0]);
                end
            end
        end

        if (reset_in) begin
            m_fill = 0; m_write = 0; m_beats = 0; m_block = '0;
            m_set = '0; m_way = '0; m_done = 0; m_err = 0; m_valid = 1;
        end else if (m_valid) begin
            nd = 0;
            if (m_write) begin
                if (array_grant_in) begin
                    m_write = 0;
                    nd = 1;
                end
            end else if (m_fill) begin
                if (mem_beat_valid_in) begin
                    m_block = m_block | (64'(mem_beat_data_in) << (BW * m_beats));
                    if (mem_beat_last_in != (m_beats == BEATS - 1)) m_err = 1;
                    m_beats++;
                    if (m_beats == BEATS) begin
                        m_fill = 0;
                        m_write = 1;
                    end
                end
            end else if (refill_req_valid_in) begin
                m_fill = 1; m_beats = 0; m_block = '0;
                m_set = refill_set_addr_in; m_way = refill_way_select_in;
            end
            m_done = nd;
        end
    end

    // ---------------- grant driver ----------------
    // While grant_hold is nonzero, withholds grant for that many WRITE cycles.
    always @(posedge clk) begin
        #1;
        if (grant_hold > 0 && access_en_out) begin
            array_grant_in = 1'b0;
            grant_hold--;
        end else begin
            array_grant_in = ($urandom_range(0, 99) < grant_pct);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_request(input logic [SW-1:0] s, input logic [NW-1:0] w);
        int n;
        n = 0;
        refill_req_valid_in  = 1'b1;
        refill_set_addr_in   = s;
        refill_way_select_in = w;
        @(negedge clk);
        while (!refill_req_ready_out && n < TMO) begin
            n++;
            @(negedge clk);
        end
        if (!refill_req_ready_out) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_timeout @cyc %0d: got ready=0 for %0d cycles, required acceptance", cyc, TMO);
        end
        @(posedge clk);
        #1;
        refill_req_valid_in  = 1'b0;
        refill_set_addr_in   = SW'($urandom);
        refill_way_select_in = NW'($urandom);
    endtask

    // gaps holds a 2-bit idle count before each beat; emask flips the last flag.
    task automatic send_beats(input logic [CW-1:0] blk, input logic [7:0] gaps,
                              input logic [3:0] emask, input int nb);
        for (int i = 0; i < nb; i++) begin
            int n;
            n = 0;
            repeat (int'(gaps[2*i +: 2])) begin
                @(posedge clk);
                #1;
            end
            mem_beat_valid_in = 1'b1;
            mem_beat_data_in  = blk[BW*i +: BW];
            mem_beat_last_in  = ((i == BEATS - 1) != emask[i]);
            @(negedge clk);
            while (!mem_beat_ready_out && n < TMO) begin
                n++;
                @(negedge clk);
            end
            if (!mem_beat_ready_out) begin
                n_cmp++;
                n_fail++;
                $display("FAIL beat_timeout @cyc %0d: got beat ready=0 for %0d cycles, required acceptance", cyc, TMO);
            end
            @(posedge clk);
            #1;
            mem_beat_valid_in = 1'b0;
            mem_beat_data_in  = BW'($urandom);
            mem_beat_last_in  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_one(input logic [SW-1:0] s, input logic [NW-1:0] w, input logic [CW-1:0] blk,
                           input logic [7:0] gaps, input logic [3:0] emask);
        exp_q.push_back({s, w, blk});
        fork
            do_request(s, w);
            send_beats(blk, gaps, emask, BEATS);
        join
    endtask

    task automatic run_pair(input logic [SW-1:0] s0, input logic [NW-1:0] w0, input logic [CW-1:0] b0,
                            input logic [SW-1:0] s1, input logic [NW-1:0] w1, input logic [CW-1:0] b1,
                            input logic [7:0] gaps);
        exp_q.push_back({s0, w0, b0});
        exp_q.push_back({s1, w1, b1});
        fork
            begin
                do_request(s0, w0);
                do_request(s1, w1);
            end
            begin
                send_beats(b0, gaps, 4'h0, BEATS);
                send_beats(b1, gaps, 4'h0, BEATS);
            end
        join
    endtask

    // Waits until every scoreboarded write has landed and its done cycle passed.
    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * TMO) begin
            n++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout @cyc %0d: got %0d writes pending, required 0", cyc, exp_q.size());
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(output int r);
        r = cyc;
        reset_in = 1'b1;
        @(posedge clk);
        #1;
        reset_in   = 1'b0;
        grant_hold = 0;
    endtask

    function automatic logic [NW-1:0] rand_way();
        logic [NW-1:0] w;
        w = '0;
        w[$urandom_range(0, NW - 1)] = 1'b1;
        return w;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk);
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got no end of test after 60000 cycles, required completion");
        finish_run();
    end

    // ---------------- main sequence ----------------
    initial begin
        int r;
        int nw0;
        int nd0;
        logic [7:0] gaps;
        logic [3:0] emask;
        int mode;

        reset_in             = 1'b1;
        refill_req_valid_in  = 1'b0;
        refill_set_addr_in   = '0;
        refill_way_select_in = '0;
        mem_beat_valid_in    = 1'b0;
        mem_beat_data_in     = '0;
        mem_beat_last_in     = 1'b0;
        array_grant_in       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        reset_in = 1'b0;

        // Reset state, pinned by literals.
        @(negedge clk);
        check("rst_ready", 64'(refill_req_ready_out), 64'd1);
        check("rst_beat_ready", 64'(mem_beat_ready_out), 64'd0);
        check("rst_wdata", write_data_out, 64'd0);
        check("rst_error", 64'(refill_error_out), 64'd0);
        @(posedge clk);
        #1;

        // Basic fill with minimum latency.
        grant_pct = 100;
        acc_log.delete();
        run_one(6'd63, 16'h8000, 64'hFFFF_FFFF_0000_0000, 8'h00, 4'h0);
        wait_drain();
        check("basic_acc_cnt", 64'(acc_log.size()), 64'd1);
        check("basic_wr_lat", 64'(wr_cyc - acc_log[0]), 64'd5);
        check("basic_done_lat", 64'(done_cyc - acc_log[0]), 64'd6);
        check("basic_wdata", last_wr_data, 64'hFFFF_FFFF_0000_0000);
        check("basic_set", 64'(last_wr_set), 64'd63);
        check("basic_readback", arr[63][15], 64'hFFFF_FFFF_0000_0000);
        check("basic_error", 64'(refill_error_out), 64'd0);

        // Grant withheld for 3 WRITE cycles.
        acc_log.delete();
        nw0 = n_writes;
        grant_hold = 3;
        run_one(6'd17, 16'h0004, 64'h0123_4567_89AB_CDEF, 8'h00, 4'h0);
        wait_drain();
        check("bp_writes", 64'(n_writes - nw0), 64'd1);
        check("bp_wr_lat", 64'(wr_cyc - acc_log[0]), 64'd8);
        check("bp_done_lat", 64'(done_cyc - acc_log[0]), 64'd9);

        // Beat valid pattern 1,0,0,1,0,1,1 from the first FILL cycle.
        acc_log.delete();
        run_one(6'd2, 16'h0100, 64'hDEAD_BEEF_CAFE_F00D, 8'h18, 4'h0);
        wait_drain();
        check("gap_wr_lat", 64'(wr_cyc - acc_log[0]), 64'd8);
        check("gap_wdata", last_wr_data, 64'hDEAD_BEEF_CAFE_F00D);

        // Framing error: last raised on beat 1; line still written.
        nd0 = n_done;
        run_one(6'd9, 16'h0002, 64'h1111_2222_3333_4444, 8'h00, 4'b0010);
        wait_drain();
        check("frame_error", 64'(refill_error_out), 64'd1);
        check("frame_done", 64'(n_done - nd0), 64'd1);
        pulse_reset(r);
        @(negedge clk);
        check("frame_cleared", 64'(refill_error_out), 64'd0);
        @(posedge clk);
        #1;

        // Reset after two beats: refill abandoned, next one accepted right away.
        nw0 = n_writes;
        nd0 = n_done;
        fork
            do_request(6'd5, 16'h0010);
            send_beats(64'hAAAA_BBBB_CCCC_DDDD, 8'h00, 4'h0, 2);
        join
        pulse_reset(r);
        acc_log.delete();
        run_one(6'd40, 16'h0040, 64'h5555_6666_7777_8888, 8'h00, 4'h0);
        wait_drain();
        check("rstfill_acc", 64'(acc_log[0] - r), 64'd1);
        check("rstfill_writes", 64'(n_writes - nw0), 64'd1);
        check("rstfill_done", 64'(n_done - nd0), 64'd1);

        // Reset while waiting for grant in WRITE.
        nw0 = n_writes;
        nd0 = n_done;
        grant_hold = 1000;
        fork
            do_request(6'd33, 16'h2000);
            send_beats(64'h0F0F_0F0F_F0F0_F0F0, 8'h00, 4'h0, BEATS);
        join
        repeat (3) @(posedge clk);
        #1;
        pulse_reset(r);
        repeat (4) @(posedge clk);
        #1;
        check("rstwr_writes", 64'(n_writes - nw0), 64'd0);
        check("rstwr_done", 64'(n_done - nd0), 64'd0);

        // Back-to-back: second request accepted in the done cycle of the first.
        grant_pct = 100;
        acc_log.delete();
        run_pair(6'd1, 16'h0001, 64'h0000_0000_0000_FFFF,
                 6'd2, 16'h0008, 64'h1234_0000_ABCD_0000, 8'h00);
        wait_drain();
        check("b2b_acc_cnt", 64'(acc_log.size()), 64'd2);
        check("b2b_spacing", 64'(acc_log[1] - acc_log[0]), 64'd6);

        // Randomized refills.
        for (int it = 0; it < 40; it++) begin
            mode      = $urandom_range(0, 7);
            grant_pct = $urandom_range(20, 100);
            gaps      = 8'($urandom);
            emask     = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            if (mode == 0) begin
                fork
                    do_request(SW'($urandom), rand_way());
                    send_beats({$urandom, $urandom}, gaps, emask, $urandom_range(0, BEATS - 1));
                join
                pulse_reset(r);
            end else if (mode == 1) begin
                run_pair(SW'($urandom), rand_way(), {$urandom, $urandom},
                         SW'($urandom), rand_way(), {$urandom, $urandom}, gaps);
            end else begin
                run_one(SW'($urandom), rand_way(), {$urandom, $urandom}, gaps, emask);
            end
            wait_drain();
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        finish_run();
    end

endmodule
